// File: rtl/wide_narrow_bank_scheduler.sv
// wide_narrow_bank_scheduler: weighted wide/narrow arbiter for one wide-bank group of shared SRAM macros.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   cfg_narrow_weight_i, cfg_wide_weight_i  contention cycles per side before yielding (0 acts as 1)
//   narrow_valid_i / narrow_ready_o      per-lane narrow request handshake
//   wide_valid_i / wide_ready_o          wide request handshake
//   bank_req_o, bank_wide_sel_o          per-macro request enables and wide data-mux select
//   narrow_rvalid_o, wide_rvalid_o       read-response valids, MemLatency cycles after grant
//   prio_wide_o                          current priority state
module wide_narrow_bank_scheduler #(
    parameter int NarrowPerWide = 4,
    parameter int MemLatency    = 1,
    parameter int WeightWidth   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WeightWidth-1:0]   cfg_narrow_weight_i,
    input  logic [WeightWidth-1:0]   cfg_wide_weight_i,
    input  logic [NarrowPerWide-1:0] narrow_valid_i,
    output logic [NarrowPerWide-1:0] narrow_ready_o,
    input  logic                     wide_valid_i,
    output logic                     wide_ready_o,
    output logic [NarrowPerWide-1:0] bank_req_o,
    output logic                     bank_wide_sel_o,
    output logic [NarrowPerWide-1:0] narrow_rvalid_o,
    output logic                     wide_rvalid_o,
    output logic                     prio_wide_o
);
    typedef enum logic {PRIO_NARROW = 1'b0, PRIO_WIDE = 1'b1} prio_e;
    prio_e                    prio_q, prio_d;
    logic [WeightWidth-1:0]   cnt_q, cnt_d, w_cfg;
    logic [WeightWidth:0]     cnt_inc, w_eff;
    logic [NarrowPerWide-1:0] ngnt;
    logic                     any_n, cont, wgnt, yield;
    logic [NarrowPerWide:0]   pipe_q [MemLatency];

    always_comb begin
        any_n           = |narrow_valid_i;
        cont            = wide_valid_i & any_n;
        // Any narrow lane blocks the whole wide access because wide spans all macros.
        wide_ready_o    = prio_q == PRIO_WIDE ? 1'b1 : ~any_n;
        narrow_ready_o  = prio_q == PRIO_WIDE && wide_valid_i ? '0 : '1;
        ngnt            = narrow_valid_i & narrow_ready_o;
        wgnt            = wide_valid_i & wide_ready_o;
        bank_req_o      = ngnt | {NarrowPerWide{wgnt}};
        bank_wide_sel_o = wgnt;
        w_cfg           = prio_q == PRIO_WIDE ? cfg_wide_weight_i : cfg_narrow_weight_i;
        w_eff           = w_cfg == '0 ? (WeightWidth+1)'(1) : {1'b0, w_cfg};
        // Extra bit keeps the compare correct when the weight is lowered below the count.
        cnt_inc         = {1'b0, cnt_q} + 1'b1;
        yield           = cont && cnt_inc >= w_eff;
        prio_d          = yield ? prio_e'(~prio_q) : prio_q;
        cnt_d           = yield ? '0 : cont ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= PRIO_NARROW;
            cnt_q  <= '0;
            for (int i = 0; i < MemLatency; i++) pipe_q[i] <= '0;
        end else begin
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            pipe_q[0] <= {wgnt, ngnt};
            for (int i = 1; i < MemLatency; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {wide_rvalid_o, narrow_rvalid_o} = pipe_q[MemLatency-1];
    assign prio_wide_o = prio_q == PRIO_WIDE;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (MemLatency >= 1 && NarrowPerWide >= 1);
            assert (!(wgnt && |ngnt));
            assert (!wide_rvalid_o || $past(wgnt, MemLatency));
            assert ((narrow_rvalid_o & ~$past(ngnt, MemLatency)) == '0);
        end
    end
endmodule

// File: tb/tb_wide_narrow_bank_scheduler.sv
// tb_wide_narrow_bank_scheduler: directed plus random checks against a cycle-level arbitration model.
module tb_wide_narrow_bank_scheduler;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] cfg_nw = 4'd1, cfg_ww = 4'd1, narrow_valid_i = '0;
    logic       wide_valid_i = 1'b0;
    logic [3:0] a_nready, a_breq, a_nrv, b_nready, b_breq, b_nrv;
    logic       a_wready, a_wsel, a_wrv, a_prio, b_wready, b_wsel, b_wrv, b_prio;

    always #5 clk_i = ~clk_i;

    wide_narrow_bank_scheduler #(.NarrowPerWide(4), .MemLatency(2), .WeightWidth(4)) u_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_narrow_weight_i(cfg_nw), .cfg_wide_weight_i(cfg_ww),
        .narrow_valid_i(narrow_valid_i), .narrow_ready_o(a_nready),
        .wide_valid_i(wide_valid_i), .wide_ready_o(a_wready),
        .bank_req_o(a_breq), .bank_wide_sel_o(a_wsel),
        .narrow_rvalid_o(a_nrv), .wide_rvalid_o(a_wrv), .prio_wide_o(a_prio));

    wide_narrow_bank_scheduler #(.NarrowPerWide(4), .MemLatency(3), .WeightWidth(4)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_narrow_weight_i(cfg_nw), .cfg_wide_weight_i(cfg_ww),
        .narrow_valid_i(narrow_valid_i), .narrow_ready_o(b_nready),
        .wide_valid_i(wide_valid_i), .wide_ready_o(b_wready),
        .bank_req_o(b_breq), .bank_wide_sel_o(b_wsel),
        .narrow_rvalid_o(b_nrv), .wide_rvalid_o(b_wrv), .prio_wide_o(b_prio));

    int n_assert = 0, n_fail = 0, cyc = 0;
    int mp = 0, mc = 0;
    logic [3:0] nw = 4'd1, ww = 4'd1;
    logic [4:0] hist[$] = '{5'd0, 5'd0, 5'd0, 5'd0};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic w, input logic [3:0] n);
        logic [3:0] enr, eng;
        logic ewr, ewg;
        int wt;
        @(negedge clk_i);
        rst_ni = ~r;
        wide_valid_i = w;
        narrow_valid_i = n;
        cfg_nw = nw;
        cfg_ww = ww;
        if (r) begin
            mp = 0;
            mc = 0;
            foreach (hist[i]) hist[i] = '0;
        end
        #1;
        enr = (mp == 1 && w) ? 4'h0 : 4'hf;
        ewr = (mp == 1) ? 1'b1 : (n == 4'h0);
        eng = n & enr;
        ewg = w & ewr;
        chk("narrow_ready", 8'(a_nready), 8'(enr));
        chk("wide_ready", 8'(a_wready), 8'(ewr));
        chk("bank_req", 8'(a_breq), 8'(eng | {4{ewg}}));
        chk("bank_wide_sel", 8'(a_wsel), 8'(ewg));
        chk("prio_wide", 8'(a_prio), 8'(mp));
        chk("rvalid_lat2", 8'({a_wrv, a_nrv}), 8'(hist[1]));
        chk("rvalid_lat3", 8'({b_wrv, b_nrv}), 8'(hist[2]));
        chk("bank_req_lat3", 8'({b_wsel, b_breq}), 8'({ewg, eng | {4{ewg}}}));
        hist.push_front(r ? 5'd0 : {ewg, eng});
        void'(hist.pop_back());
        if (!r && w && n != 4'h0) begin
            wt = (mp == 1) ? int'(ww) : int'(nw);
            if (wt == 0) wt = 1;
            if (mc + 1 >= wt) begin
                mp = 1 - mp;
                mc = 0;
            end else mc++;
        end
        cyc++;
    endtask

    initial begin
        repeat (3) tick(1'b1, 1'b0, 4'h0);
        // strict alternation from reset release
        nw = 4'd1; ww = 4'd1;
        repeat (10) tick(1'b0, 1'b1, 4'hf);
        // narrow weight 3, wide weight 1
        tick(1'b1, 1'b0, 4'h0);
        nw = 4'd3; ww = 4'd1;
        repeat (16) tick(1'b0, 1'b1, 4'hf);
        // wide alone never moves priority
        tick(1'b1, 1'b0, 4'h0);
        repeat (10) tick(1'b0, 1'b1, 4'h0);
        // single lane contention, then wide turn
        nw = 4'd1;
        tick(1'b0, 1'b1, 4'b0100);
        tick(1'b0, 1'b1, 4'b0100);
        tick(1'b0, 1'b0, 4'h0);
        // zero weights act as one
        tick(1'b1, 1'b0, 4'h0);
        nw = 4'd0; ww = 4'd0;
        repeat (8) tick(1'b0, 1'b1, 4'hf);
        // wide weight lowered 4 -> 1 while count is 2
        tick(1'b1, 1'b0, 4'h0);
        nw = 4'd1; ww = 4'd4;
        for (int k = 0; k < 20 && !(mp == 1 && mc == 2); k++) tick(1'b0, 1'b1, 4'hf);
        ww = 4'd1;
        repeat (4) tick(1'b0, 1'b1, 4'hf);
        // reset one cycle after a wide grant drops the response
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b1, 4'h0);
        tick(1'b1, 1'b0, 4'h0);
        repeat (4) tick(1'b0, 1'b0, 4'h0);
        repeat (3) tick(1'b0, 1'b1, 4'h3);
        // random traffic with weight changes and occasional resets
        for (int k = 0; k < 400; k++) begin
            if (k % 16 == 0) begin
                nw = 4'($urandom_range(0, 5));
                ww = 4'($urandom_range(0, 5));
            end
            tick($urandom_range(0, 39) == 0, 1'($urandom), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
